// File: rtl/multi_cycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl_pkg
// Shared encodings for the RV32I multi-cycle control unit:
//   - ALUOP_* codes (shared with the ALU)
//   - FSM state encoding
//   - alu_src_a / alu_src_b / imm_sel / pc_sel / wb_sel field encodings
//   - RV32I base opcode constants
//   - instr_is_legal(): the decode-time legality rule
// -----------------------------------------------------------------------------
package multi_cycle_ctrl_pkg;

   // ALU operation codes
   localparam logic [4:0] ALUOP_ADD   = 5'd0;
   localparam logic [4:0] ALUOP_SUB   = 5'd1;
   localparam logic [4:0] ALUOP_SLL   = 5'd2;
   localparam logic [4:0] ALUOP_SLT   = 5'd3;
   localparam logic [4:0] ALUOP_SLTU  = 5'd4;
   localparam logic [4:0] ALUOP_XOR   = 5'd5;
   localparam logic [4:0] ALUOP_SRL   = 5'd6;
   localparam logic [4:0] ALUOP_SRA   = 5'd7;
   localparam logic [4:0] ALUOP_OR    = 5'd8;
   localparam logic [4:0] ALUOP_AND   = 5'd9;
   localparam logic [4:0] ALUOP_LUI   = 5'd10;
   localparam logic [4:0] ALUOP_AUIPC = 5'd11;
   localparam logic [4:0] ALUOP_BEQ   = 5'd12;
   localparam logic [4:0] ALUOP_BNE   = 5'd13;
   localparam logic [4:0] ALUOP_BLT   = 5'd14;
   localparam logic [4:0] ALUOP_BGE   = 5'd15;
   localparam logic [4:0] ALUOP_BLTU  = 5'd16;
   localparam logic [4:0] ALUOP_BGEU  = 5'd17;
   localparam logic [4:0] ALUOP_JALR  = 5'd18;

   // FSM states
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   // Operand select encodings
   localparam logic [1:0] SRC_A_RS1   = 2'd0;
   localparam logic [1:0] SRC_A_PC    = 2'd1;
   localparam logic [1:0] SRC_A_OLDPC = 2'd2;

   localparam logic [1:0] SRC_B_RS2   = 2'd0;
   localparam logic [1:0] SRC_B_IMM   = 2'd1;
   localparam logic [1:0] SRC_B_FOUR  = 2'd2;

   // Immediate format select
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   // Next-PC source
   localparam logic [1:0] PC_SEL_ALU    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;  // OLDPC + imm
   localparam logic [1:0] PC_SEL_JALR   = 2'd2;  // ALU result, bit 0 cleared

   // Write-back source
   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC  = 2'd2;

   // RV32I base opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Legal = opcode in the base set, and for branches funct3 is not 010/011.
   function automatic logic instr_is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
      logic ok;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
         OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: ok = 1'b1;
         OPC_BRANCH:                              ok = (funct3[2:1] != 2'b01);
         default:                                 ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl_if
// Control bus between the multi-cycle controller (master) and the datapath
// (slave).
//   instr[31:0]   IR contents into the controller
//   zero          ALU Zero flag into the controller
//   mem_rdy       memory completes the current access this cycle
//   alu_op[4:0]   ALU operation code
//   alu_src_a/b   operand selects
//   imm_sel[2:0]  immediate format
//   pc_sel/wb_sel next-PC and write-back sources
//   pc_we, ir_we, rf_we, mem_re, mem_we   write/access strobes
//   illegal, retire                       one-cycle status pulses
// -----------------------------------------------------------------------------
interface multi_cycle_ctrl_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_rdy;
   logic [4:0]  alu_op;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  imm_sel;
   logic        pc_we;
   logic        ir_we;
   logic        rf_we;
   logic        mem_re;
   logic        mem_we;
   logic [1:0]  pc_sel;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic        retire;

   modport master (
      input  instr, zero, mem_rdy,
      output alu_op, alu_src_a, alu_src_b, imm_sel,
             pc_we, ir_we, rf_we, mem_re, mem_we,
             pc_sel, wb_sel, illegal, retire
   );

   modport slave (
      output instr, zero, mem_rdy,
      input  alu_op, alu_src_a, alu_src_b, imm_sel,
             pc_we, ir_we, rf_we, mem_re, mem_we,
             pc_sel, wb_sel, illegal, retire
   );
endinterface

// File: rtl/multi_cycle_ctrl_alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational map from opcode / funct3 / funct7[5] to an ALUOP_* code.
//   i_opcode[6:0]   instruction opcode
//   i_funct3[2:0]   instruction funct3
//   i_funct7_b5     instruction bit 30
//   o_alu_op[4:0]   ALU operation code (ADD for anything not listed)
// -----------------------------------------------------------------------------
module alu_op_decode
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7_b5,
   output logic [4:0] o_alu_op
);

   always_comb begin
      o_alu_op = ALUOP_ADD;
      case (i_opcode)
         OPC_OP, OPC_OPIMM: begin
            case (i_funct3)
               // bit 30 of an I-type is immediate data except for shifts,
               // so SUB only exists for register-register ops
               3'b000:  o_alu_op = (i_opcode == OPC_OP && i_funct7_b5) ? ALUOP_SUB : ALUOP_ADD;
               3'b001:  o_alu_op = ALUOP_SLL;
               3'b010:  o_alu_op = ALUOP_SLT;
               3'b011:  o_alu_op = ALUOP_SLTU;
               3'b100:  o_alu_op = ALUOP_XOR;
               3'b101:  o_alu_op = i_funct7_b5 ? ALUOP_SRA : ALUOP_SRL;
               3'b110:  o_alu_op = ALUOP_OR;
               default: o_alu_op = ALUOP_AND;
            endcase
         end
         OPC_BRANCH: begin
            case (i_funct3)
               3'b000:  o_alu_op = ALUOP_BEQ;
               3'b001:  o_alu_op = ALUOP_BNE;
               3'b100:  o_alu_op = ALUOP_BLT;
               3'b101:  o_alu_op = ALUOP_BGE;
               3'b110:  o_alu_op = ALUOP_BLTU;
               3'b111:  o_alu_op = ALUOP_BGEU;
               default: o_alu_op = ALUOP_ADD;
            endcase
         end
         OPC_LUI:   o_alu_op = ALUOP_LUI;
         OPC_AUIPC: o_alu_op = ALUOP_AUIPC;
         OPC_JALR:  o_alu_op = ALUOP_JALR;
         default:   o_alu_op = ALUOP_ADD;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
// RV32I multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   RESET_PC_SEL  pc_sel value presented while rstn is low
//   clk           rising-edge clock
//   rstn          asynchronous active-low reset
//   bus           control bus (master side); all outputs are combinational
//                 from state, instr, zero and mem_rdy
// -----------------------------------------------------------------------------
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
   input  logic                  clk,
   input  logic                  rstn,
   multi_cycle_ctrl_if.master    bus
);

   state_e     r_state;
   state_e     w_state_next;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_funct7_b5;
   logic       w_is_load;
   logic       w_is_store;
   logic [4:0] w_dec_alu_op;
   logic       w_unused;

   logic [4:0] w_alu_op;
   logic [1:0] w_src_a;
   logic [1:0] w_src_b;
   logic [2:0] w_imm_sel;
   logic [1:0] w_pc_sel;
   logic [1:0] w_wb_sel;
   logic       w_pc_we;
   logic       w_ir_we;
   logic       w_rf_we;
   logic       w_mem_re;
   logic       w_mem_we;
   logic       w_illegal;
   logic       w_retire;

   assign w_opcode    = bus.instr[6:0];
   assign w_funct3    = bus.instr[14:12];
   assign w_funct7_b5 = bus.instr[30];
   assign w_is_load   = (w_opcode == OPC_LOAD);
   assign w_is_store  = (w_opcode == OPC_STORE);

   // Register fields are the datapath's business, not the controller's.
   assign w_unused = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

   alu_op_decode u_alu_op_decode (
      .i_opcode    (w_opcode),
      .i_funct3    (w_funct3),
      .i_funct7_b5 (w_funct7_b5),
      .o_alu_op    (w_dec_alu_op)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_alu_op     = ALUOP_ADD;
      w_src_a      = SRC_A_RS1;
      w_src_b      = SRC_B_RS2;
      w_imm_sel    = IMM_I;
      w_pc_sel     = PC_SEL_ALU;
      w_wb_sel     = WB_SEL_ALU;
      w_pc_we      = 1'b0;
      w_ir_we      = 1'b0;
      w_rf_we      = 1'b0;
      w_mem_re     = 1'b0;
      w_mem_we     = 1'b0;
      w_illegal    = 1'b0;
      w_retire     = 1'b0;

      // Gating on rstn here (not only in the state register) makes the
      // strobes drop in the same instant reset is asserted, so an aborted
      // instruction never completes a write.
      if (!rstn) begin
         w_pc_sel     = RESET_PC_SEL;
         w_state_next = ST_FETCH;
      end else begin
         case (r_state)
            ST_FETCH: begin
               w_mem_re = 1'b1;
               w_src_a  = SRC_A_PC;
               w_src_b  = SRC_B_FOUR;
               if (bus.mem_rdy) begin
                  w_ir_we      = 1'b1;
                  w_pc_we      = 1'b1;
                  w_state_next = ST_DECODE;
               end
            end

            ST_DECODE: begin
               if (instr_is_legal(w_opcode, w_funct3)) begin
                  w_state_next = ST_EXEC;
               end else begin
                  w_illegal    = 1'b1;
                  w_state_next = ST_FETCH;
               end
            end

            ST_EXEC: begin
               w_alu_op = w_dec_alu_op;
               case (w_opcode)
                  OPC_OP: begin
                     w_state_next = ST_WB;
                  end
                  OPC_OPIMM: begin
                     w_src_b      = SRC_B_IMM;
                     w_state_next = ST_WB;
                  end
                  OPC_LUI: begin
                     w_src_b      = SRC_B_IMM;
                     w_imm_sel    = IMM_U;
                     w_state_next = ST_WB;
                  end
                  OPC_AUIPC: begin
                     w_src_a      = SRC_A_OLDPC;
                     w_src_b      = SRC_B_IMM;
                     w_imm_sel    = IMM_U;
                     w_state_next = ST_WB;
                  end
                  OPC_LOAD: begin
                     w_src_b      = SRC_B_IMM;
                     w_state_next = ST_MEM;
                  end
                  OPC_STORE: begin
                     w_src_b      = SRC_B_IMM;
                     w_imm_sel    = IMM_S;
                     w_state_next = ST_MEM;
                  end
                  OPC_BRANCH: begin
                     // ALU compares rs1/rs2; target comes from OLDPC + B-imm
                     w_imm_sel    = IMM_B;
                     w_pc_we      = bus.zero;
                     w_pc_sel     = PC_SEL_BRANCH;
                     w_retire     = 1'b1;
                     w_state_next = ST_FETCH;
                  end
                  OPC_JAL: begin
                     w_imm_sel    = IMM_J;
                     w_pc_we      = 1'b1;
                     w_pc_sel     = PC_SEL_BRANCH;
                     w_rf_we      = 1'b1;
                     w_wb_sel     = WB_SEL_PC;
                     w_retire     = 1'b1;
                     w_state_next = ST_FETCH;
                  end
                  OPC_JALR: begin
                     w_src_b      = SRC_B_IMM;
                     w_pc_we      = 1'b1;
                     w_pc_sel     = PC_SEL_JALR;
                     w_rf_we      = 1'b1;
                     w_wb_sel     = WB_SEL_PC;
                     w_retire     = 1'b1;
                     w_state_next = ST_FETCH;
                  end
                  default: begin
                     w_state_next = ST_FETCH;
                  end
               endcase
            end

            ST_MEM: begin
               // Address stays on the ALU output for the whole access
               w_src_b   = SRC_B_IMM;
               w_imm_sel = w_is_store ? IMM_S : IMM_I;
               if (w_is_store) begin
                  w_mem_we = 1'b1;
               end else begin
                  w_mem_re = 1'b1;
               end
               if (bus.mem_rdy) begin
                  if (w_is_store) begin
                     w_retire     = 1'b1;
                     w_state_next = ST_FETCH;
                  end else begin
                     w_state_next = ST_WB;
                  end
               end
            end

            ST_WB: begin
               w_rf_we      = 1'b1;
               w_wb_sel     = w_is_load ? WB_SEL_MEM : WB_SEL_ALU;
               w_retire     = 1'b1;
               w_state_next = ST_FETCH;
            end

            default: begin
               w_state_next = ST_FETCH;
            end
         endcase
      end
   end

   assign bus.alu_op    = w_alu_op;
   assign bus.alu_src_a = w_src_a;
   assign bus.alu_src_b = w_src_b;
   assign bus.imm_sel   = w_imm_sel;
   assign bus.pc_sel    = w_pc_sel;
   assign bus.wb_sel    = w_wb_sel;
   assign bus.pc_we     = w_pc_we;
   assign bus.ir_we     = w_ir_we;
   assign bus.rf_we     = w_rf_we;
   assign bus.mem_re    = w_mem_re;
   assign bus.mem_we    = w_mem_we;
   assign bus.illegal   = w_illegal;
   assign bus.retire    = w_retire;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Drives instructions through multi_cycle_ctrl and compares every cycle of
// control outputs against a per-instruction cycle script built from the
// instruction-level rules.
// -----------------------------------------------------------------------------
module tb_multi_cycle_ctrl;
   import multi_cycle_ctrl_pkg::*;

   localparam logic [1:0] RST_PC_SEL = 2'd2;

   typedef struct packed {
      logic [4:0] alu_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [2:0] imm_sel;
      logic [1:0] pc_sel;
      logic [1:0] wb_sel;
      logic       pc_we;
      logic       ir_we;
      logic       rf_we;
      logic       mem_re;
      logic       mem_we;
      logic       illegal;
      logic       retire;
   } obs_t;

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_fail;
   obs_t obs_q[$];
   obs_t exp_q[$];

   multi_cycle_ctrl_if bus ();

   multi_cycle_ctrl #(.RESET_PC_SEL(RST_PC_SEL)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.alu_op  = bus.alu_op;   o.src_a  = bus.alu_src_a; o.src_b   = bus.alu_src_b;
      o.imm_sel = bus.imm_sel;  o.pc_sel = bus.pc_sel;    o.wb_sel  = bus.wb_sel;
      o.pc_we   = bus.pc_we;    o.ir_we  = bus.ir_we;     o.rf_we   = bus.rf_we;
      o.mem_re  = bus.mem_re;   o.mem_we = bus.mem_we;    o.illegal = bus.illegal;
      o.retire  = bus.retire;
      return o;
   endfunction

   // Run one instruction starting in FETCH. mem_rdy is low for the first fst
   // cycles and again for mst cycles starting where MEM would begin.
   task automatic exec_instr(input logic [31:0] ins, input logic z, input int fst, input int mst);
      obs_q.delete();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bus.instr   = ins;
         bus.zero    = z;
         bus.mem_rdy = !((k < fst) || (k >= fst + 3 && k < fst + 3 + mst));
         #2;
         obs_q.push_back(sample());
         if (bus.retire || bus.illegal) break;
      end
   endtask

   function automatic logic [4:0] ref_arith(input logic [2:0] f3, input logic b5, input logic is_reg);
      logic [4:0] t [8];
      t = '{ALUOP_ADD, ALUOP_SLL, ALUOP_SLT, ALUOP_SLTU, ALUOP_XOR, ALUOP_SRL, ALUOP_OR, ALUOP_AND};
      if (f3 == 3'd0 && is_reg && b5) return ALUOP_SUB;
      if (f3 == 3'd5 && b5) return ALUOP_SRA;
      return t[f3];
   endfunction

   function automatic logic [4:0] ref_branch(input logic [2:0] f3);
      logic [4:0] t [8];
      t = '{ALUOP_BEQ, ALUOP_BNE, ALUOP_ADD, ALUOP_ADD, ALUOP_BLT, ALUOP_BGE, ALUOP_BLTU, ALUOP_BGEU};
      return t[f3];
   endfunction

   // Reference: expected output vector for every cycle of one instruction.
   function automatic void build_exp(input logic [31:0] ins, input logic z, input int fst, input int mst);
      obs_t f, d, e, m, w;
      logic [6:0] opc;
      logic [2:0] f3;
      logic b5, legal, goes_wb;
      opc = ins[6:0]; f3 = ins[14:12]; b5 = ins[30];
      exp_q.delete();
      f = '0; f.alu_op = ALUOP_ADD; f.src_a = 2'd1; f.src_b = 2'd2; f.mem_re = 1'b1;
      for (int k = 0; k < fst; k++) exp_q.push_back(f);
      f.ir_we = 1'b1; f.pc_we = 1'b1;
      exp_q.push_back(f);
      legal = (opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h13, 7'h33})
              || (opc == 7'h63 && !(f3 inside {3'd2, 3'd3}));
      d = '0; d.alu_op = ALUOP_ADD; d.illegal = !legal;
      exp_q.push_back(d);
      if (!legal) return;
      e = '0; e.alu_op = ALUOP_ADD; goes_wb = 1'b1;
      case (opc)
         7'h33: e.alu_op = ref_arith(f3, b5, 1'b1);
         7'h13: begin e.alu_op = ref_arith(f3, b5, 1'b0); e.src_b = 2'd1; end
         7'h37: begin e.alu_op = ALUOP_LUI; e.src_b = 2'd1; e.imm_sel = 3'd3; end
         7'h17: begin e.alu_op = ALUOP_AUIPC; e.src_a = 2'd2; e.src_b = 2'd1; e.imm_sel = 3'd3; end
         7'h03, 7'h23: begin
            e.src_b = 2'd1; e.imm_sel = (opc == 7'h23) ? 3'd1 : 3'd0;
            exp_q.push_back(e);
            m = e;
            if (opc == 7'h23) m.mem_we = 1'b1; else m.mem_re = 1'b1;
            for (int k = 0; k < mst; k++) exp_q.push_back(m);
            if (opc == 7'h23) begin m.retire = 1'b1; exp_q.push_back(m); return; end
            exp_q.push_back(m);
            w = '0; w.alu_op = ALUOP_ADD; w.rf_we = 1'b1; w.wb_sel = 2'd1; w.retire = 1'b1;
            exp_q.push_back(w);
            return;
         end
         7'h63: begin
            e.alu_op = ref_branch(f3); e.imm_sel = 3'd2; e.pc_we = z; e.pc_sel = 2'd1;
            e.retire = 1'b1; goes_wb = 1'b0;
         end
         7'h6F: begin
            e.imm_sel = 3'd4; e.pc_we = 1'b1; e.pc_sel = 2'd1; e.rf_we = 1'b1;
            e.wb_sel = 2'd2; e.retire = 1'b1; goes_wb = 1'b0;
         end
         default: begin // JALR
            e.alu_op = ALUOP_JALR; e.src_b = 2'd1; e.pc_we = 1'b1; e.pc_sel = 2'd2;
            e.rf_we = 1'b1; e.wb_sel = 2'd2; e.retire = 1'b1; goes_wb = 1'b0;
         end
      endcase
      exp_q.push_back(e);
      if (goes_wb) begin
         w = '0; w.alu_op = ALUOP_ADD; w.rf_we = 1'b1; w.retire = 1'b1;
         exp_q.push_back(w);
      end
   endfunction

   task automatic test_reset();
      obs_t r, o;
      r = '0; r.alu_op = ALUOP_ADD; r.pc_sel = RST_PC_SEL;
      rstn = 1'b0; bus.instr = 32'h0000_0013; bus.zero = 1'b0; bus.mem_rdy = 1'b1;
      repeat (3) begin
         @(negedge clk); #2;
         o = sample();
         n_checks++;
         if (o !== r) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", o, r);
         end
      end
      bus.mem_rdy = 1'b0;
      @(negedge clk); rstn = 1'b1; #2;
      n_checks++;
      if (bus.mem_re !== 1'b1 || bus.ir_we !== 1'b0 || bus.pc_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_first_fetch: got mem_re=%b ir_we=%b pc_sel=%0d want 1 0 0",
                  bus.mem_re, bus.ir_we, bus.pc_sel);
      end
      $display("test_reset done");
   endtask

   task automatic test_add();
      int rets;
      exec_instr(32'h0020_81B3, 1'b0, 0, 0);
      n_checks++;
      if (obs_q.size() != 4) begin
         n_fail++; $display("FAIL add_cycles: got %0d want 4", obs_q.size());
      end else begin
         n_checks++;
         if (obs_q[2].alu_op !== ALUOP_ADD) begin
            n_fail++; $display("FAIL add_aluop: got %0d want %0d", obs_q[2].alu_op, ALUOP_ADD);
         end
         n_checks++;
         if (obs_q[3].rf_we !== 1'b1 || obs_q[3].wb_sel !== 2'd0) begin
            n_fail++; $display("FAIL add_wb: got rf_we=%b wb_sel=%0d want 1 0", obs_q[3].rf_we, obs_q[3].wb_sel);
         end
      end
      rets = 0;
      foreach (obs_q[i]) rets += int'(obs_q[i].retire);
      n_checks++;
      if (rets != 1) begin
         n_fail++; $display("FAIL add_retire_count: got %0d want 1", rets);
      end
      $display("test_add: add x3,x1,x2 cycles=%0d", obs_q.size());
   endtask

   task automatic test_alu_ops();
      logic [31:0] ins [3];
      logic [4:0]  want [3];
      ins  = '{32'h4020_81B3, 32'h4030_D193, 32'h0050_B193};
      want = '{ALUOP_SUB, ALUOP_SRA, ALUOP_SLTU};
      for (int t = 0; t < 3; t++) begin
         exec_instr(ins[t], 1'b0, 0, 0);
         n_checks++;
         if (obs_q.size() != 4) begin
            n_fail++; $display("FAIL aluop_cycles[%0d]: got %0d want 4", t, obs_q.size());
         end else begin
            n_checks++;
            if (obs_q[2].alu_op !== want[t]) begin
               n_fail++; $display("FAIL aluop_code[%0d]: got %0d want %0d", t, obs_q[2].alu_op, want[t]);
            end
            n_checks++;
            if (obs_q[2].src_b !== ((t == 0) ? 2'd0 : 2'd1)) begin
               n_fail++; $display("FAIL aluop_srcb[%0d]: got %0d want %0d", t, obs_q[2].src_b, (t == 0) ? 0 : 1);
            end
         end
         $display("test_alu_ops: instr=%h alu_op=%0d", ins[t], obs_q[obs_q.size()-1].alu_op);
      end
   endtask

   task automatic test_branch();
      for (int z = 1; z >= 0; z--) begin
         exec_instr(32'h0020_8463, z[0], 0, 0);
         n_checks++;
         if (obs_q.size() != 3) begin
            n_fail++; $display("FAIL beq_cycles z=%0d: got %0d want 3", z, obs_q.size());
         end else begin
            n_checks++;
            if (obs_q[2].pc_we !== z[0] || obs_q[2].pc_sel !== 2'd1 || obs_q[2].alu_op !== ALUOP_BEQ) begin
               n_fail++;
               $display("FAIL beq_exec z=%0d: got pc_we=%b pc_sel=%0d alu_op=%0d want %0d 1 %0d",
                        z, obs_q[2].pc_we, obs_q[2].pc_sel, obs_q[2].alu_op, z, ALUOP_BEQ);
            end
         end
         $display("test_branch: beq zero=%0d cycles=%0d", z, obs_q.size());
      end
   endtask

   task automatic test_load_stall();
      exec_instr(32'h0000_A183, 1'b0, 0, 2);
      n_checks++;
      if (obs_q.size() != 7) begin
         n_fail++; $display("FAIL lw_cycles: got %0d want 7", obs_q.size());
      end else begin
         for (int i = 3; i < 6; i++) begin
            n_checks++;
            if (obs_q[i].mem_re !== 1'b1 || obs_q[i].mem_we !== 1'b0) begin
               n_fail++; $display("FAIL lw_mem_re[%0d]: got re=%b we=%b want 1 0", i, obs_q[i].mem_re, obs_q[i].mem_we);
            end
         end
         n_checks++;
         if (obs_q[6].rf_we !== 1'b1 || obs_q[6].wb_sel !== 2'd1) begin
            n_fail++; $display("FAIL lw_wb: got rf_we=%b wb_sel=%0d want 1 1", obs_q[6].rf_we, obs_q[6].wb_sel);
         end
      end
      $display("test_load_stall: lw cycles=%0d", obs_q.size());
   endtask

   task automatic test_illegal();
      exec_instr(32'h0000_007F, 1'b0, 0, 0);
      n_checks++;
      if (obs_q.size() != 2 || obs_q[obs_q.size()-1].illegal !== 1'b1) begin
         n_fail++; $display("FAIL illegal_pulse: got cycles=%0d want 2 with illegal in DECODE", obs_q.size());
      end else begin
         n_checks++;
         if (obs_q[1].rf_we || obs_q[1].mem_we || obs_q[1].pc_we || obs_q[1].retire) begin
            n_fail++; $display("FAIL illegal_writes: got vector %h want no strobes", obs_q[1]);
         end
      end
      @(negedge clk); bus.mem_rdy = 1'b0; #2;
      n_checks++;
      if (bus.mem_re !== 1'b1) begin
         n_fail++; $display("FAIL illegal_refetch: got mem_re=%b want 1", bus.mem_re);
      end
      $display("test_illegal: instr=0000007f cycles=%0d", obs_q.size());
   endtask

   task automatic test_reset_mid_store();
      @(negedge clk); bus.instr = 32'h0020_A023; bus.mem_rdy = 1'b1;   // FETCH
      @(negedge clk);                                                  // DECODE
      @(negedge clk);                                                  // EXEC
      @(negedge clk); bus.mem_rdy = 1'b0; #2;                          // MEM, stalled
      n_checks++;
      if (bus.mem_we !== 1'b1) begin
         n_fail++; $display("FAIL sw_mem_we: got %b want 1", bus.mem_we);
      end
      #1 rstn = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.retire !== 1'b0 || bus.pc_sel !== RST_PC_SEL) begin
         n_fail++;
         $display("FAIL sw_abort: got we=%b re=%b retire=%b pc_sel=%0d want 0 0 0 %0d",
                  bus.mem_we, bus.mem_re, bus.retire, bus.pc_sel, RST_PC_SEL);
      end
      @(negedge clk); rstn = 1'b1; #2;
      n_checks++;
      if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0) begin
         n_fail++; $display("FAIL sw_restart: got re=%b we=%b want 1 0", bus.mem_re, bus.mem_we);
      end
      exec_instr(32'h0020_81B3, 1'b0, 0, 0);
      n_checks++;
      if (obs_q.size() != 4) begin
         n_fail++; $display("FAIL sw_recover_cycles: got %0d want 4", obs_q.size());
      end
      $display("test_reset_mid_store: recovery add cycles=%0d", obs_q.size());
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic        z;
      int          fst, mst, sel, n;
      logic [6:0]  opcs [9];
      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      for (int t = 0; t < 80; t++) begin
         ins = $urandom;
         sel = $urandom_range(0, 10);
         if (sel < 9) ins[6:0] = opcs[sel];
         else if (sel == 10) begin ins[6:0] = 7'h63; ins[14:13] = 2'b01; end
         z   = 1'($urandom_range(0, 1));
         fst = $urandom_range(0, 2);
         mst = $urandom_range(0, 2);
         exec_instr(ins, z, fst, mst);
         build_exp(ins, z, fst, mst);
         n_checks++;
         if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_cycles[%0d]: instr=%h got %0d want %0d", t, ins, obs_q.size(), exp_q.size());
         end
         n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
         for (int i = 0; i < n; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL rand_vec[%0d] cycle %0d: instr=%h got %h want %h", t, i, ins, obs_q[i], exp_q[i]);
               break;
            end
         end
         $display("test_random[%0d]: instr=%h zero=%0d fst=%0d mst=%0d cycles=%0d",
                  t, ins, z, fst, mst, obs_q.size());
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_add();
      test_alu_ops();
      test_branch();
      test_load_stall();
      test_illegal();
      test_reset_mid_store();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
